ua_transmitter: RTL and testbench
=================================

# ua_transmitter

Serial UART transmitter that is the transmit counterpart of the team's UART receiver. It accepts bytes over a valid/ready handshake, buffers one byte, and shifts out 8N1 frames (or 8N2) on `ser_out`: start bit 0, 8 data bits LSB first, then stop bit(s) 1. It runs on the same `enable` oversample tick as the receiver, 16 ticks per bit, so a receiver fed the same tick samples mid-bit.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `enable` ticks per bit; legal range 2..16; bit timer is 4 bits wide.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  oversample tick; the bit timer and FSM advance only when this is high.
- `din_byte`  in  8  byte to transmit.
- `din_valid`  in  1  `din_byte` is valid.
- `din_ready`  out  1  holding register empty; a byte is accepted on a `clk` edge where `din_valid && din_ready`.
- `ser_out`  out  1  registered serial line; idles at 1.
- `tx_busy`  out  1  a frame is on the line (FSM not IDLE).
- `tx_done`  out  1  one-`clk` pulse when the last stop bit completes.

## Operation
- Reset values: `ser_out`=1, `din_ready`=1, `tx_busy`=0, `tx_done`=0, FSM=IDLE, timer=0, bit index=0, holding register empty.
- Handshake acceptance does not depend on `enable`. An accept loads `hold_reg` and sets `hold_full`. `din_ready = ~hold_full`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on an `enable` tick with `hold_full`, copy `hold_reg` into the shift register, clear `hold_full`, and drive `ser_out` to 0. Go to START with timer 0.
  - START: after `OVERSAMPLE` ticks, drive bit 0 of the shift register and go to DATA with bit index 0.
  - DATA: each time `OVERSAMPLE` ticks elapse, shift right and drive the next bit. After bit 7 completes, drive 1 and go to STOP.
  - STOP: hold 1 for `STOP_BITS*OVERSAMPLE` ticks. On the final tick, pulse `tx_done`. If `hold_full`, go straight to START: load the shifter and drive 0 on that same edge, with no idle gap. Otherwise go to IDLE.
- Bit timer: counts 0..`OVERSAMPLE`-1 on `enable` ticks and wraps to 0 at the bit boundary. No arithmetic wider than 4 bits.
- `enable` low: timer, FSM, `ser_out` and the shift register all freeze. Handshake acceptance continues.
- Simultaneous events: if the holding register empties into the shifter on the same edge as a new byte arrives, the new byte wins `hold_reg` and `hold_full` stays 1. This is legal only when `din_ready` was 1 before the edge, which the `~hold_full` rule already enforces.
- Reset mid-frame: the line returns to 1 immediately (asynchronously), and the partial frame and any held byte are discarded.
- `tx_busy` = (state != IDLE), registered alongside state.

## Timing
- Throughput: one frame per `(10 + STOP_BITS - 1) * OVERSAMPLE` enable ticks when back-to-back. That is 160 ticks for the defaults.
- Accept-to-start latency from IDLE: the start bit appears on the first `enable`-high edge strictly after the accept edge. With `enable` tied high this is 1 clk.
- `din_ready` returns high 1 clk after the byte moves into the shifter. This allows a second byte to be queued during the first frame.
- `tx_done` asserts for exactly 1 clk, on the edge that ends the stop bit. It coincides with the next start bit when back-to-back.
- Every bit is exactly `OVERSAMPLE` `enable` ticks wide, including across back-to-back frame boundaries.

## Structure
- Shared package `ua_pkg` holds:
  - `UA_DATA_BITS`=8, `UA_START_LVL`=1'b0, `UA_STOP_LVL`=1'b1, `UA_IDLE_LVL`=1'b1.
  - The 2-bit FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
- The package is shared with the receiver for frame constants.
- One sub-module is natural: `ua_bit_timer`. It takes `clk`, `rst`, `enable` and `clear`, and outputs `bit_end`, pulsed on the last tick of a bit. It is parameterised by `OVERSAMPLE` and reusable by the receiver.

## Test plan
- Single byte 0xA5, `enable` tied high, defaults. Required `ser_out` sequence: 0,1,0,1,0,0,1,0,1,1, each level held 16 clk. `tx_done` pulses at clk 160 after the start bit begins. `tx_busy` drops on the same edge.
- Back-to-back 0x00 then 0xFF, second byte offered while the first is in DATA. The second byte is accepted while the first frame is still in DATA, then `din_ready` stays low for the rest of the first frame. The second start bit follows the first stop bit with zero gap.
- `enable` pulsed 1-in-4 clk, byte 0x3C: each bit lasts 64 clk. The frame decodes as 0x3C.
- Loopback with the team's receiver on a shared `enable`, bytes 0x00, 0x55, 0xAA, 0xFF, 0x81. The receiver reports the same bytes with valid start and stop framing.
- `rst` asserted mid-DATA of 0x5A with a second byte held. `ser_out`=1 during reset, `din_ready`=1 and `tx_busy`=0 after release, and no further frame is sent.
- `STOP_BITS`=2, byte 0x01: the stop level lasts 32 ticks. `tx_done` fires at tick 176.

Source files
------------

// File: rtl/ua_pkg.sv
// Frame constants and FSM encoding shared by the UART transmitter and receiver.
package ua_pkg;

   localparam int   UA_DATA_BITS = 8;
   localparam logic UA_START_LVL = 1'b0;
   localparam logic UA_STOP_LVL  = 1'b1;
   localparam logic UA_IDLE_LVL  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } ua_state_e;

endpackage

// File: rtl/ua_bit_timer.sv
// Oversample bit timer: counts enable ticks 0..OVERSAMPLE-1 and flags the last tick of each bit.
module ua_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic bit_end
);

   // Counter is 4 bits, so OVERSAMPLE must stay within 2..16.
   localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 4'd0;
      end else if (enable) begin
         count_d = (count_q == LAST) ? 4'd0 : count_q + 4'd1;
      end
   end

   assign bit_end = enable && !clear && (count_q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ua_transmitter.sv
// UART transmitter: one-byte holding register feeding an 8N1/8N2 shifter paced by the oversample tick.
module ua_transmitter import ua_pkg::*; #(
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] din_byte,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       ser_out,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam logic [2:0] DATA_LAST = 3'(UA_DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   ua_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] hold_reg_q, hold_reg_d;
   logic       hold_full_q, hold_full_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       ser_out_q, ser_out_d;
   logic       tx_busy_q, tx_busy_d;
   logic       tx_done_q, tx_done_d;

   logic       accept;
   logic       load;
   logic       bit_end;

   assign accept = din_valid && !hold_full_q;

   ua_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bit_timer (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .clear  (state_q == ST_IDLE),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_reg_d  = hold_reg_q;
      hold_full_d = hold_full_q;
      bit_idx_d   = bit_idx_q;
      ser_out_d   = ser_out_q;
      tx_done_d   = 1'b0;
      load        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && hold_full_q) begin
               load      = 1'b1;
               ser_out_d = UA_START_LVL;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               ser_out_d = shift_q[0];
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == DATA_LAST) begin
                  ser_out_d = UA_STOP_LVL;
                  bit_idx_d = 3'd0;
                  state_d   = ST_STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  ser_out_d = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_idx_q == STOP_LAST) begin
                  tx_done_d = 1'b1;
                  bit_idx_d = 3'd0;
                  // A queued byte starts on this same edge so frames abut with no idle gap.
                  if (hold_full_q) begin
                     load      = 1'b1;
                     ser_out_d = UA_START_LVL;
                     state_d   = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         shift_d     = hold_reg_q;
         hold_full_d = 1'b0;
      end
      // A new byte arriving as the old one leaves must keep the register full.
      if (accept) begin
         hold_reg_d  = din_byte;
         hold_full_d = 1'b1;
      end

      tx_busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= 8'd0;
         hold_reg_q  <= 8'd0;
         hold_full_q <= 1'b0;
         bit_idx_q   <= 3'd0;
         ser_out_q   <= UA_IDLE_LVL;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_reg_q  <= hold_reg_d;
         hold_full_q <= hold_full_d;
         bit_idx_q   <= bit_idx_d;
         ser_out_q   <= ser_out_d;
         tx_busy_q   <= tx_busy_d;
         tx_done_q   <= tx_done_d;
      end
   end

   assign din_ready = !hold_full_q;
   assign ser_out   = ser_out_q;
   assign tx_busy   = tx_busy_q;
   assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_ua_transmitter.sv
// Bench for ua_transmitter: table-driven frame checks, multi-cycle corner sequences and a
// randomized run decoded by an independent mid-bit sampling UART receiver model.
module tb_ua_transmitter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] din_byte = 8'd0;
   logic       din_valid = 1'b0;
   logic       din_ready, ser_out, tx_busy, tx_done;

   logic [7:0] din_byte2 = 8'd0;
   logic       din_valid2 = 1'b0;
   logic       din_ready2, ser_out2, tx_busy2, tx_done2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int en_period = 1;

   logic [7:0] exp_q[$];
   logic [9:0] rx_q[$];

   typedef struct {
      logic [7:0] data;
      int         period;
      logic [9:0] frame;   // line levels in transmit order, bit 0 first
   } vec_t;

   vec_t vecs[3];

   ua_transmitter dut (
      .clk(clk), .rst(rst), .enable(enable), .din_byte(din_byte), .din_valid(din_valid),
      .din_ready(din_ready), .ser_out(ser_out), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   ua_transmitter #(.STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .din_byte(din_byte2), .din_valid(din_valid2),
      .din_ready(din_ready2), .ser_out(ser_out2), .tx_busy(tx_busy2), .tx_done(tx_done2)
   );

   always #5 clk = ~clk;

   // Enable generator: edge n carries a tick when (n-1) % en_period == 0.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         enable = ((cyc % en_period) == 0);
      end
   end

   // Reference receiver: detect the start level on a tick, then sample each bit mid-way.
   initial begin
      int         dcnt;
      logic [9:0] dsh;
      bit         en_s;
      dcnt = -1;
      dsh  = '0;
      forever begin
         @(posedge clk);
         en_s = enable;
         #2;
         if (rst) begin
            dcnt = -1;
         end else if (en_s) begin
            if (dcnt < 0) begin
               if (ser_out == 1'b0) dcnt = 0;
            end else begin
               dcnt++;
               if (dcnt >= 8 && ((dcnt - 8) % 16) == 0) begin
                  dsh[(dcnt - 8) / 16] = ser_out;
                  if (dcnt == 152) begin
                     rx_q.push_back(dsh);
                     dcnt = -1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 900000");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s = %0h", nm, act);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!din_ready && n < 5000) begin
         step();
         n++;
      end
      if (!din_ready) chk("send_ready_timeout", din_ready, 1);
      din_byte  = b;
      din_valid = 1'b1;
      exp_q.push_back(b);
      step();
      din_valid = 1'b0;
   endtask

   task automatic wait_start(output int t0);
      int n = 0;
      while (ser_out !== 1'b0 && n < 2000) begin
         step();
         n++;
      end
      chk("start_seen", ser_out, 0);
      t0 = cyc;
   endtask

   task automatic check_frame(input int t0, input int p, input logic [9:0] fr,
                              input bit next_pending, input string tag);
      wait_cyc(t0 + 8*p);
      chk($sformatf("%s_start_mid", tag), ser_out, fr[0]);
      wait_cyc(t0 + 16*p - 1);
      chk($sformatf("%s_start_last", tag), ser_out, 0);
      for (int i = 1; i < 10; i++) begin
         wait_cyc(t0 + 16*p*i + 8*p);
         chk($sformatf("%s_bit%0d", tag, i), ser_out, fr[i]);
      end
      wait_cyc(t0 + 160*p - 1);
      chk($sformatf("%s_done_early", tag), tx_done, 0);
      chk($sformatf("%s_busy_in_frame", tag), tx_busy, 1);
      wait_cyc(t0 + 160*p);
      chk($sformatf("%s_done", tag), tx_done, 1);
      chk($sformatf("%s_busy_after", tag), tx_busy, next_pending);
      chk($sformatf("%s_line_after", tag), ser_out, next_pending ? 0 : 1);
      step();
      chk($sformatf("%s_done_pulse", tag), tx_done, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(tx_busy == 1'b0 && din_ready == 1'b1) && n < 20000) begin
         step();
         n++;
      end
      chk("idle_reached", tx_busy, 0);
      repeat (4) step();
   endtask

   initial begin
      int t0, t2, acc, es;
      bit saw_low;
      logic [7:0] loop_bytes[5];

      vecs[0] = '{8'hA5, 1, 10'h34A};
      vecs[1] = '{8'h3C, 4, 10'h278};
      vecs[2] = '{8'h5A, 2, 10'h2B4};
      loop_bytes[0] = 8'h00; loop_bytes[1] = 8'h55; loop_bytes[2] = 8'hAA;
      loop_bytes[3] = 8'hFF; loop_bytes[4] = 8'h81;

      repeat (3) step();
      chk("rst_ser_out", ser_out, 1);
      chk("rst_din_ready", din_ready, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_tx_done", tx_done, 0);
      rst = 1'b0;
      step();

      // Table-driven single frames at several enable rates
      for (int v = 0; v < 3; v++) begin
         en_period = vecs[v].period;
         repeat (2 * en_period + 1) step();
         send_byte(vecs[v].data);
         acc = cyc;
         wait_start(t0);
         es = acc + 1;
         while (((es - 1) % vecs[v].period) != 0) es++;
         chk($sformatf("vec%0d_latency", v), t0, es);
         check_frame(t0, vecs[v].period, vecs[v].frame, 1'b0, $sformatf("vec%0d", v));
         repeat (3) step();
      end

      // Back-to-back 0x00 then 0xFF, second byte queued during DATA
      en_period = 1;
      step();
      send_byte(8'h00);
      wait_start(t0);
      fork
         check_frame(t0, 1, 10'h200, 1'b1, "b2b0");
         begin
            wait_cyc(t0 + 40);
            send_byte(8'hFF);
            chk("b2b_queued_ready", din_ready, 0);
            wait_cyc(t0 + 159);
            chk("b2b_ready_held", din_ready, 0);
            wait_cyc(t0 + 160);
            chk("b2b_ready_after_load", din_ready, 1);
         end
      join
      check_frame(t0 + 160, 1, 10'h3FE, 1'b0, "b2b1");
      repeat (3) step();

      // Reset mid-DATA with a second byte held
      send_byte(8'h5A);
      wait_start(t0);
      wait_cyc(t0 + 20);
      send_byte(8'h77);
      chk("rst_seq_held", din_ready, 0);
      wait_cyc(t0 + 24);
      chk("rst_seq_line_low", ser_out, 0);
      #3 rst = 1'b1;
      #1 chk("rst_async_line", ser_out, 1);
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_rel_ready", din_ready, 1);
      chk("rst_rel_busy", tx_busy, 0);
      saw_low = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (ser_out !== 1'b1) saw_low = 1'b1;
      end
      chk("rst_no_frame", saw_low, 0);

      // Two stop bits on the second instance, byte 0x01
      din_byte2  = 8'h01;
      din_valid2 = 1'b1;
      step();
      din_valid2 = 1'b0;
      t2 = 0;
      for (int i = 0; i < 100 && ser_out2 !== 1'b0; i++) step();
      chk("sb2_start", ser_out2, 0);
      t2 = cyc;
      wait_cyc(t2 + 24);
      chk("sb2_bit0", ser_out2, 1);
      wait_cyc(t2 + 40);
      chk("sb2_bit1", ser_out2, 0);
      wait_cyc(t2 + 160);
      chk("sb2_stop_at160", ser_out2, 1);
      chk("sb2_no_done160", tx_done2, 0);
      wait_cyc(t2 + 175);
      chk("sb2_line175", ser_out2, 1);
      chk("sb2_done_early", tx_done2, 0);
      chk("sb2_busy175", tx_busy2, 1);
      wait_cyc(t2 + 176);
      chk("sb2_done", tx_done2, 1);
      chk("sb2_busy_after", tx_busy2, 0);

      // Randomized traffic against the reference receiver
      repeat (4) step();
      exp_q.delete();
      rx_q.delete();
      en_period = 1;
      step();
      for (int i = 0; i < 5; i++) send_byte(loop_bytes[i]);
      wait_idle();
      for (int b = 0; b < 3; b++) begin
         en_period = $urandom_range(1, 3);
         repeat (4) step();
         for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 250)) step();
            send_byte(8'($urandom));
         end
         wait_idle();
      end
      chk("rx_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chk($sformatf("rx%0d_byte", i), rx_q[i][8:1], exp_q[i]);
         chk($sformatf("rx%0d_framing", i), {rx_q[i][9], rx_q[i][0]}, 2'b10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
